// File: rtl/uart_tx_sched_pkg.sv
// Shared constants for the UART transmit scheduler: FSM state encoding,
// request length encoding and the timeout counter width helper.
package uart_tx_sched_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEND    = 2'd1;
  localparam logic [1:0] ST_WAIT_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO = 2'd3;

  localparam logic LEN_1B = 1'b0;
  localparam logic LEN_2B = 1'b1;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_sched_arb.sv
// Requester arbiter for uart_tx_sched. Fixed priority (requester 0 highest)
// by default; round-robin with a wrapping pointer when UART_TX_SCHED_RR_EN is defined.
module uart_tx_sched_arb
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
`ifdef UART_TX_SCHED_RR_EN
  input  logic               CLK,
  input  logic               RST,
  input  logic               take,
`endif
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

`ifdef UART_TX_SCHED_RR_EN
  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] next_ptr;
  logic             found;
  int               idx;

  // Search starts at the pointer and wraps, so the last winner goes to the back.
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = PTR_W'((idx + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr <= '0;
    end else if (take) begin
      ptr <= next_ptr;
    end
  end
`else
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler sharing one UART TX serializer between NUM_REQ requesters.
// Optional round-robin arbitration is enabled with the UART_TX_SCHED_RR_EN macro.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REQ      = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*2*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]              req_len,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            tx_busy,
  output logic                            tx_valid,
  output logic [DATA_WIDTH-1:0]           tx_data,
  output logic                            sched_idle
);

  localparam int                CNT_W    = cnt_width(BUSY_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BUSY_TIMEOUT - 2);

  logic [1:0]              state;
  logic                    byte_idx;
  logic [CNT_W-1:0]        cnt;
  logic [2*DATA_WIDTH-1:0] shadow_data;
  logic                    shadow_len;

  logic                    can_grant;
  logic                    take;
  logic [NUM_REQ-1:0]      grant;
  logic [2*DATA_WIDTH-1:0] gnt_data;
  logic                    gnt_len;

  assign can_grant = (state == ST_IDLE) && !tx_busy;
  assign take      = can_grant && (|req_valid);

  uart_tx_sched_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
`ifdef UART_TX_SCHED_RR_EN
    .CLK   (CLK),
    .RST   (RST),
    .take  (take),
`endif
    .req   (req_valid & {NUM_REQ{can_grant}}),
    .grant (grant)
  );

  always_comb begin
    gnt_data = '0;
    gnt_len  = LEN_1B;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_data = req_data[i*2*DATA_WIDTH +: 2*DATA_WIDTH];
        gnt_len  = req_len[i];
      end
    end
  end

  // tx_valid/tx_data are loaded on every transition into SEND, so the pulse
  // lines up with the SEND cycle and tx_data holds until the next byte.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= ST_IDLE;
      req_ready   <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      sched_idle  <= 1'b1;
      byte_idx    <= 1'b0;
      cnt         <= '0;
      shadow_data <= '0;
      shadow_len  <= LEN_1B;
    end else begin
      req_ready <= '0;
      tx_valid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            req_ready   <= grant;
            shadow_data <= gnt_data;
            shadow_len  <= gnt_len;
            byte_idx    <= 1'b0;
            tx_data     <= gnt_data[DATA_WIDTH-1:0];
            tx_valid    <= 1'b1;
            sched_idle  <= 1'b0;
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          cnt   <= '0;
          state <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (tx_busy) begin
            state <= ST_WAIT_LO;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              tx_valid <= 1'b1;
              state    <= ST_SEND;
            end
          end
        end
        ST_WAIT_LO: begin
          if (!tx_busy) begin
            if (byte_idx == shadow_len) begin
              sched_idle <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              byte_idx <= 1'b1;
              tx_data  <= shadow_data[2*DATA_WIDTH-1:DATA_WIDTH];
              tx_valid <= 1'b1;
              state    <= ST_SEND;
            end
          end
        end
        default: begin
          sched_idle <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
